// File: rtl/encoder_input_frontend.sv
// Rotary-encoder input conditioning: pin synchronisers, full-detent quadrature
// decoding with a wrapping position count, and pushbutton debouncing.
module encoder_input_frontend #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic                 btn_n,
  input  logic                 count_clr,
  output logic                 step_valid,
  output logic                 step_dir,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 enc_err,
  output logic                 btn_level,
  output logic                 btn_press,
  output logic                 btn_release
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

  logic                 a_s1_q, a_s2_q, b_s1_q, b_s2_q, btn_s1_q, btn_s2_q;
  logic [1:0]           prev_q;
  logic [2:0]           acc_q, acc_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 step_valid_q, step_dir_q, enc_err_q;
  logic                 step_d, dir_d, err_d;
  logic [DB_W-1:0]      db_cnt_q, db_cnt_d;
  logic                 btn_level_q, btn_level_d, btn_press_q, btn_press_d;
  logic                 btn_release_q, btn_release_d;
  logic [1:0]           cur;
  logic                 is_cw, is_ccw;
  logic [3:0]           acc_sum;
  logic                 btn_pressed;

  function automatic logic [1:0] cw_next(input logic [1:0] s);
    case (s)
      2'b00:   cw_next = 2'b01;
      2'b01:   cw_next = 2'b11;
      2'b11:   cw_next = 2'b10;
      default: cw_next = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] ccw_next(input logic [1:0] s);
    case (s)
      2'b00:   ccw_next = 2'b10;
      2'b10:   ccw_next = 2'b11;
      2'b11:   ccw_next = 2'b01;
      default: ccw_next = 2'b00;
    endcase
  endfunction

  // The accumulator is widened by one bit here so +4 and -4 stay distinct.
  always_comb begin
    cur     = {b_s2_q, a_s2_q};
    is_cw   = (cur != prev_q) && (cur == cw_next(prev_q));
    is_ccw  = (cur != prev_q) && (cur == ccw_next(prev_q));
    err_d   = (cur == ~prev_q);
    acc_sum = {acc_q[2], acc_q};
    if (is_cw)  acc_sum = acc_sum + 4'd1;
    if (is_ccw) acc_sum = acc_sum - 4'd1;
    step_d  = (cur == 2'b00) && (is_cw || is_ccw) &&
              ((acc_sum == 4'b0100) || (acc_sum == 4'b1100));
    dir_d   = (acc_sum == 4'b0100);
    acc_d   = acc_q;
    if (cur != prev_q) begin
      if (err_d || (cur == 2'b00)) acc_d = 3'd0;
      else                         acc_d = acc_sum[2:0];
    end
    count_d = count_q;
    if (count_clr)   count_d = '0;
    else if (step_d) count_d = dir_d ? count_q + CNT_WIDTH'(1) : count_q - CNT_WIDTH'(1);
  end

  always_comb begin
    btn_pressed   = ~btn_s2_q;
    db_cnt_d      = '0;
    btn_level_d   = btn_level_q;
    btn_press_d   = 1'b0;
    btn_release_d = 1'b0;
    if (btn_pressed != btn_level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_level_d   = btn_pressed;
        btn_press_d   = btn_pressed;
        btn_release_d = ~btn_pressed;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_s1_q        <= 1'b0;
      a_s2_q        <= 1'b0;
      b_s1_q        <= 1'b0;
      b_s2_q        <= 1'b0;
      btn_s1_q      <= 1'b1;
      btn_s2_q      <= 1'b1;
      prev_q        <= 2'b00;
      acc_q         <= 3'd0;
      count_q       <= '0;
      step_valid_q  <= 1'b0;
      step_dir_q    <= 1'b0;
      enc_err_q     <= 1'b0;
      db_cnt_q      <= '0;
      btn_level_q   <= 1'b0;
      btn_press_q   <= 1'b0;
      btn_release_q <= 1'b0;
    end else begin
      a_s1_q        <= enc_a;
      a_s2_q        <= a_s1_q;
      b_s1_q        <= enc_b;
      b_s2_q        <= b_s1_q;
      btn_s1_q      <= btn_n;
      btn_s2_q      <= btn_s1_q;
      prev_q        <= cur;
      acc_q         <= acc_d;
      count_q       <= count_d;
      step_valid_q  <= step_d;
      step_dir_q    <= step_d & dir_d;
      enc_err_q     <= err_d;
      db_cnt_q      <= db_cnt_d;
      btn_level_q   <= btn_level_d;
      btn_press_q   <= btn_press_d;
      btn_release_q <= btn_release_d;
    end
  end

  assign step_valid  = step_valid_q;
  assign step_dir    = step_dir_q;
  assign count       = count_q;
  assign enc_err     = enc_err_q;
  assign btn_level   = btn_level_q;
  assign btn_press   = btn_press_q;
  assign btn_release = btn_release_q;

endmodule

// File: tb/tb_encoder_input_frontend.sv
// Bench for encoder_input_frontend: table of quadrature sequences with a step
// scoreboard, plus hand-written button, clear-collision and mid-rotation reset cases.
module tb_encoder_input_frontend;

  localparam int CW = 8;
  localparam int DB = 16;

  logic          clk = 1'b0;
  logic          rst, enc_a, enc_b, btn_n, count_clr;
  logic          step_valid, step_dir, enc_err, btn_level, btn_press, btn_release;
  logic [CW-1:0] count;

  encoder_input_frontend #(.DEBOUNCE_CYCLES(DB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .btn_n(btn_n),
    .count_clr(count_clr), .step_valid(step_valid), .step_dir(step_dir),
    .count(count), .enc_err(enc_err), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  int            err_seen = 0;
  int            press_seen = 0;
  int            release_seen = 0;
  logic [CW:0]   exp_q[$];
  logic [CW-1:0] model_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Step scoreboard: each step pulse must match the oldest expected {dir, count}.
  always @(negedge clk) begin
    if (!rst) begin
      if (step_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_step: got dir=%0d count=%0d expected no step", step_dir, count);
        end else begin
          check("step_dir_count", {23'd0, step_dir, count}, {23'd0, exp_q.pop_front()});
        end
      end
      if (enc_err)     err_seen++;
      if (btn_press)   press_seen++;
      if (btn_release) release_seen++;
    end
  end

  task automatic drive_state(input logic [1:0] s);
    @(negedge clk);
    {enc_b, enc_a} = s;
    repeat (9) @(negedge clk);
  endtask

  task automatic expect_steps(input int n, input logic dir);
    for (int i = 0; i < n; i++) begin
      model_cnt = dir ? model_cnt + 8'd1 : model_cnt - 8'd1;
      exp_q.push_back({dir, model_cnt});
    end
  endtask

  task automatic cw_cycle();
    expect_steps(1, 1'b1);
    drive_state(2'b01);
    drive_state(2'b11);
    drive_state(2'b10);
    drive_state(2'b00);
  endtask

  // Returns the edge index (0 = capture edge) of the first btn pulse of the given kind.
  task automatic btn_edge(input logic level, input bit want_press, output int first_k);
    @(negedge clk);
    btn_n = level;
    first_k = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (first_k < 0 && (want_press ? btn_press : btn_release)) first_k = k;
    end
  endtask

  typedef struct {
    logic [0:7][1:0] seq;
    int              len;
    int              n_steps;
    logic            dir;
    int              n_errs;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "bench timed out");
  end

  initial begin
    int e0, p0, r0, k;
    vecs[0] = '{seq: {2'b01,2'b11,2'b10,2'b00,2'b01,2'b11,2'b10,2'b00}, len: 8, n_steps: 2, dir: 1'b1, n_errs: 0};
    vecs[1] = '{seq: {2'b10,2'b11,2'b01,2'b00,2'b10,2'b11,2'b01,2'b00}, len: 8, n_steps: 2, dir: 1'b0, n_errs: 0};
    vecs[2] = '{seq: {2'b10,2'b11,2'b01,2'b00,2'b00,2'b00,2'b00,2'b00}, len: 4, n_steps: 1, dir: 1'b0, n_errs: 0};
    vecs[3] = '{seq: {2'b01,2'b11,2'b10,2'b00,2'b00,2'b00,2'b00,2'b00}, len: 4, n_steps: 1, dir: 1'b1, n_errs: 0};
    vecs[4] = '{seq: {2'b01,2'b00,2'b01,2'b11,2'b01,2'b00,2'b00,2'b00}, len: 6, n_steps: 0, dir: 1'b0, n_errs: 0};
    vecs[5] = '{seq: {2'b11,2'b10,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00}, len: 3, n_steps: 0, dir: 1'b0, n_errs: 1};
    vecs[6] = '{seq: {2'b01,2'b11,2'b10,2'b00,2'b00,2'b00,2'b00,2'b00}, len: 4, n_steps: 1, dir: 1'b1, n_errs: 0};
    vecs[7] = '{seq: {2'b11,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00}, len: 2, n_steps: 0, dir: 1'b0, n_errs: 2};
    vecs[8] = '{seq: {2'b01,2'b11,2'b01,2'b00,2'b00,2'b00,2'b00,2'b00}, len: 4, n_steps: 0, dir: 1'b0, n_errs: 0};

    rst = 1'b1; enc_a = 1'b0; enc_b = 1'b0; btn_n = 1'b1; count_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", {18'd0, step_valid, step_dir, enc_err, btn_level, btn_press, btn_release, count}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int r = 0; r < 9; r++) begin
      e0 = err_seen;
      expect_steps(vecs[r].n_steps, vecs[r].dir);
      for (int i = 0; i < vecs[r].len; i++) drive_state(vecs[r].seq[i]);
      repeat (5) @(negedge clk);
      check($sformatf("vec%0d_pending_steps", r), exp_q.size(), 0);
      check($sformatf("vec%0d_enc_err", r), err_seen - e0, vecs[r].n_errs);
      check($sformatf("vec%0d_count", r), {24'd0, count}, {24'd0, model_cnt});
    end

    // count_clr collides with the step that would take count from 5 to 6.
    while (model_cnt != 8'd5) cw_cycle();
    repeat (3) @(negedge clk);
    check("pre_clr_count", {24'd0, count}, 32'd5);
    drive_state(2'b01);
    drive_state(2'b11);
    drive_state(2'b10);
    model_cnt = '0;
    exp_q.push_back({1'b1, 8'd0});
    @(negedge clk);
    {enc_b, enc_a} = 2'b00;
    repeat (2) @(negedge clk);
    count_clr = 1'b1;
    @(negedge clk);
    count_clr = 1'b0;
    repeat (8) @(negedge clk);
    check("clr_pending_steps", exp_q.size(), 0);
    check("clr_count", {24'd0, count}, 32'd0);

    // Button: short glitch, then a held press and release.
    p0 = press_seen;
    @(negedge clk);
    btn_n = 1'b0;
    repeat (10) @(negedge clk);
    btn_n = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_press", press_seen - p0, 0);
    check("glitch_level", {31'd0, btn_level}, 32'd0);
    p0 = press_seen;
    btn_edge(1'b0, 1'b1, k);
    check("press_edge", k, 17);
    @(negedge clk);
    check("press_count", press_seen - p0, 1);
    check("press_level", {31'd0, btn_level}, 32'd1);
    r0 = release_seen;
    btn_edge(1'b1, 1'b0, k);
    check("release_edge", k, 17);
    @(negedge clk);
    check("release_count", release_seen - r0, 1);
    check("release_level", {31'd0, btn_level}, 32'd0);

    // Mid-rotation reset: partial accumulation must not complete a detent.
    cw_cycle();
    drive_state(2'b01);
    drive_state(2'b11);
    check("pre_rst_count", {24'd0, count}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async_outs", {18'd0, step_valid, step_dir, enc_err, btn_level, btn_press, btn_release, count}, 32'd0);
    model_cnt = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    e0 = err_seen;
    drive_state(2'b10);
    drive_state(2'b00);
    repeat (5) @(negedge clk);
    check("post_rst_pending_steps", exp_q.size(), 0);
    check("post_rst_enc_err", err_seen - e0, 1);
    check("post_rst_count", {24'd0, count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
